// File: rtl/pop_count_pkg.sv
// Shared types and helpers for the multi-cycle population counter.
// Holds the FSM state type and the result-width function cnt_w().
package pop_count_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold any value 0..width inclusive.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/pop_count_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
// Ports: bits_i (CHUNK bits in), ones_o (number of set bits).
module pop_count_chunk
   import pop_count_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0]          bits_i,
   output logic [cnt_w(CHUNK)-1:0]   ones_o
);

   localparam int OW = cnt_w(CHUNK);

   always_comb begin
      ones_o = '0;
      for (int i = 0; i < CHUNK; i++) begin
         ones_o = ones_o + OW'(bits_i[i]);
      end
   end

endmodule

// File: rtl/pop_count_param.sv
// Multi-cycle popcount: CHUNK bits per RUN cycle, WIDTH/CHUNK cycles.
// Ports: clk, rst (sync, active-low), start, input_number, count_zeros,
//        count, busy, done; parity when POP_COUNT_PARITY_EN is defined.
module pop_count_param
   import pop_count_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          input_number,
   input  logic                      count_zeros,
   output logic [cnt_w(WIDTH)-1:0]   count,
`ifdef POP_COUNT_PARITY_EN
   output logic                      parity,
`endif
   output logic                      busy,
   output logic                      done
);

   localparam int CNT_W  = cnt_w(WIDTH);
   localparam int CH_W   = cnt_w(CHUNK);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

   if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
      $error("pop_count_param: WIDTH must be 2..256");
   end
   if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("pop_count_param: CHUNK must be 1..WIDTH");
   end
   if (WIDTH % CHUNK != 0) begin : g_bad_div
      $error("pop_count_param: WIDTH must be a multiple of CHUNK");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic               busy_q, done_q;
   logic [CH_W-1:0]    ones;

   pop_count_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .bits_i (sh_q[CHUNK-1:0]),
      .ones_o (ones)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = count_zeros ? ~input_number : input_number;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(ones);
            sh_d  = sh_q >> CHUNK;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // busy/done are their own flops, loaded from the next state,
   // so they never glitch and can never both be high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

`ifdef POP_COUNT_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= cnt_d[0];
      end
   end

   assign parity = par_q;
`endif

   assign count = cnt_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_pop_count_param.sv
// Directed bench for pop_count_param at 32/4 and 10/1.
// Checks latency, results, hold, reset abort and input isolation.
module tb_pop_count_param;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start32 = 1'b0, cz32 = 1'b0;
   logic [31:0] in32 = '0;
   logic [5:0]  cnt32;
   logic        busy32, done32;
   logic        start10 = 1'b0, cz10 = 1'b0;
   logic [9:0]  in10 = '0;
   logic [3:0]  cnt10;
   logic        busy10, done10;
   logic        par32, par10;
   logic        sel = 1'b1;

   int pass  = 0;
   int total = 0;

   always #5 clk = ~clk;

   pop_count_param #(.WIDTH(32), .CHUNK(4)) u32 (
      .clk          (clk),
      .rst          (rst),
      .start        (start32),
      .input_number (in32),
      .count_zeros  (cz32),
      .count        (cnt32),
`ifdef POP_COUNT_PARITY_EN
      .parity       (par32),
`endif
      .busy         (busy32),
      .done         (done32)
   );

   pop_count_param #(.WIDTH(10), .CHUNK(1)) u10 (
      .clk          (clk),
      .rst          (rst),
      .start        (start10),
      .input_number (in10),
      .count_zeros  (cz10),
      .count        (cnt10),
`ifdef POP_COUNT_PARITY_EN
      .parity       (par10),
`endif
      .busy         (busy10),
      .done         (done10)
   );

`ifndef POP_COUNT_PARITY_EN
   assign par32 = 1'b0;
   assign par10 = 1'b0;
`endif

   wire [5:0] cnt_s  = sel ? cnt32 : {2'b00, cnt10};
   wire       busy_s = sel ? busy32 : busy10;
   wire       done_s = sel ? done32 : done10;
   wire       par_s  = sel ? par32 : par10;

   typedef struct {
      bit          w;
      logic [31:0] v;
      bit          cz;
      int          exp;
      string       name;
   } vec_t;

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask

   task automatic drive(input bit w, input bit s,
                        input logic [31:0] v, input bit cz);
      if (w) begin
         start32 = s; in32 = v; cz32 = cz;
      end else begin
         start10 = s; in10 = v[9:0]; cz10 = cz;
      end
   endtask

   task automatic wait_done(input bit w, output int lat, output int bad,
                            input bit tog, input logic [31:0] v);
      logic [31:0] cur;
      bit          c;
      cur = v; c = 1'b0;
      lat = 0; bad = 0;
      while (!done_s && lat < 40) begin
         if (!busy_s) bad++;
         if (tog) begin
            cur = ~cur; c = ~c;
            drive(w, 1'b0, cur, c);
         end
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run(input bit w, input logic [31:0] v, input bit cz,
                      input int exp, input string n, input bit tog);
      int lat, bad;
      sel = w;
      @(negedge clk);
      drive(w, 1'b1, v, cz);
      @(negedge clk);
      drive(w, 1'b0, v, cz);
      chk({n, " accept clears count"}, int'(cnt_s), 0);
      wait_done(w, lat, bad, tog, v);
      chk({n, " latency"}, lat, w ? 8 : 10);
      chk({n, " busy during run"}, bad, 0);
      chk({n, " count"}, int'(cnt_s), exp);
`ifdef POP_COUNT_PARITY_EN
      chk({n, " parity"}, int'(par_s), exp % 2);
`endif
      @(negedge clk);
      chk({n, " idle flags"}, {busy_s, done_s}, 0);
      chk({n, " idle hold"}, int'(cnt_s), exp);
   endtask

   vec_t vecs[$];

   initial begin
      int lat, bad;

      vecs.push_back('{1, 32'hFFFF_FFFF, 0, 32, "ones_all"});
      vecs.push_back('{1, 32'h8000_0001, 1, 30, "zeros_8001"});
      vecs.push_back('{1, 32'h0000_0000, 0, 0,  "ones_zero"});
      vecs.push_back('{1, 32'h0000_0000, 1, 32, "zeros_zero"});
      vecs.push_back('{1, 32'h1234_5678, 0, 13, "ones_1234"});
      vecs.push_back('{1, 32'h1234_5678, 1, 19, "zeros_1234"});
      vecs.push_back('{1, 32'hF0F0_F0F0, 0, 16, "ones_f0f0"});
      vecs.push_back('{1, 32'h8000_0000, 0, 1,  "ones_msb"});
      vecs.push_back('{0, 32'h0000_02AA, 0, 5,  "w10_2aa"});
      vecs.push_back('{0, 32'h0000_03FF, 0, 10, "w10_max"});
      vecs.push_back('{0, 32'h0000_0201, 1, 8,  "w10_zeros"});

      repeat (3) @(negedge clk);
      chk("reset count32", int'(cnt32), 0);
      chk("reset flags32", {busy32, done32}, 0);
      chk("reset count10", int'(cnt10), 0);
      chk("reset flags10", {busy10, done10}, 0);
`ifdef POP_COUNT_PARITY_EN
      chk("reset parity", int'(par32), 0);
`endif
      rst = 1'b1;

      foreach (vecs[i]) begin
         run(vecs[i].w, vecs[i].v, vecs[i].cz, vecs[i].exp, vecs[i].name, 0);
      end

      // start held high through DONE
      sel = 1'b1;
      @(negedge clk);
      drive(1, 1'b1, 32'h0000_FFFF, 0);
      @(negedge clk);
      wait_done(1, lat, bad, 0, 32'h0);
      chk("hold latency", lat, 8);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold done", int'(done32), 1);
         chk("hold count", int'(cnt32), 16);
      end
      drive(1, 1'b0, 32'h0000_FFFF, 0);
      @(negedge clk);
      chk("hold release", int'(done32), 0);
      drive(1, 1'b1, 32'h0000_000F, 0);
      @(negedge clk);
      drive(1, 1'b0, 32'h0000_000F, 0);
      chk("restart clear", int'(cnt32), 0);
      chk("restart busy", int'(busy32), 1);
      wait_done(1, lat, bad, 0, 32'h0);
      chk("restart count", int'(cnt32), 4);
      @(negedge clk);

      // reset during RUN, then reset beating start
      drive(1, 1'b1, 32'hFFFF_FFFF, 0);
      @(negedge clk);
      drive(1, 1'b0, 32'hFFFF_FFFF, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort flags", {busy32, done32}, 0);
      chk("abort count", int'(cnt32), 0);
      drive(1, 1'b1, 32'hFFFF_FFFF, 0);
      @(negedge clk);
      chk("reset beats start", int'(busy32), 0);
      drive(1, 1'b0, 32'hFFFF_FFFF, 0);
      rst = 1'b1;
      run(1, 32'h0F0F_0F0F, 0, 16, "post_reset", 0);

      // inputs toggling during RUN must not matter
      run(1, 32'h0000_0007, 0, 3, "toggle32", 1);
      run(0, 32'h0000_0155, 1, 5, "toggle10", 1);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/pop_count_param.md
POP_COUNT_PARAM -- requirements
Module: pop_count_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input word width in bits, legal range 2..256.
REQ-002 SHALL have parameter CHUNK, default 4: bits examined per RUN cycle, 1..WIDTH; WIDTH % CHUNK == 0 is required and is checked at elaboration.
REQ-003 SHALL have port clk, input, 1: the single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: request or acknowledge level.
REQ-006 SHALL have port input_number, input, WIDTH: operand, sampled only at the accepting edge.
REQ-007 SHALL have port count_zeros, input, 1: 0 = count ones, 1 = count zeros; sampled with input_number.
REQ-008 SHALL have port count, output, CNT_W = clog2(WIDTH+1): the registered result.
REQ-009 SHALL have port busy, output, 1: high while in RUN.
REQ-010 SHALL have port done, output, 1: high while in DONE.

Function
REQ-011 SHALL use the FSM states IDLE, RUN and DONE, one-hot or binary, with no other reachable states.
REQ-012 SHALL, in IDLE with start=1 at an edge: load the shift register with input_number (bitwise inverted if count_zeros=1), clear count and the chunk index, and go to RUN.
REQ-013 SHALL, on each RUN edge: add the popcount of shift_reg[CHUNK-1:0] to count, shift shift_reg right by CHUNK, and increment the index.
REQ-014 SHALL go from RUN to DONE on the edge that processes chunk NCHUNK-1, where NCHUNK = WIDTH/CHUNK.
REQ-015 SHALL have fixed latency: done is high exactly NCHUNK cycles after the accepting edge (32/4 gives 8 cycles; 10/1 gives 10 cycles), independent of data.
REQ-016 SHALL go from DONE to IDLE on the first edge with start=0; while start stays 1, it remains in DONE and does not restart.
REQ-017 SHALL ignore start, input_number and count_zeros during RUN; changing them during RUN does not affect the result.
REQ-018 SHALL hold count stable in DONE and in the following IDLE until the next accepting edge, and clear it on that edge.
REQ-019 SHALL keep count from overflowing: the maximum is WIDTH, and CNT_W holds WIDTH exactly (WIDTH=32 gives 6 bits).
REQ-020 SHALL make busy and done mutually exclusive and drive both directly from state flops, with no combinational path from inputs.
REQ-021 SHALL force any illegal state encoding to IDLE on the next edge.

Reset
REQ-022 SHALL, on an edge with rst=0, set state to IDLE and clear count, busy, done, the index and shift_reg.
REQ-023 SHALL, when reset is asserted mid-RUN or in DONE, abandon the operation with no partial result visible; the first accept after reset is released starts a fresh count.
REQ-024 SHALL give reset priority over start at the same edge.

Configuration
REQ-025 SHALL, when macro POP_COUNT_PARITY_EN is defined, add output parity (1 bit) equal to count[0], registered, valid while done=1, and 0 after reset.
REQ-026 SHALL, when POP_COUNT_PARITY_EN is undefined, have no parity port or logic, with all other behaviour identical.

Structure
REQ-027 SHALL place in the shared package pop_count_pkg: the state typedef (IDLE/RUN/DONE) and the function cnt_w(width) = clog2(width+1).
REQ-028 SHALL have one combinational sub-module, pop_count_chunk, with parameter CHUNK: CHUNK-bit input, clog2(CHUNK+1)-bit ones count.
REQ-029 SHALL instantiate pop_count_chunk once in pop_count_param, so the datapath adder is CNT_W bits.

Verification
REQ-030 SHALL verify WIDTH=32, CHUNK=4: input 0xFFFFFFFF, count_zeros=0, start pulse -> busy for 8 cycles, then done=1, count=32, parity=0.
REQ-031 SHALL verify WIDTH=32, CHUNK=4: input 0x80000001, count_zeros=1 -> count=30; input 0x00000000, count_zeros=0 -> count=0 after 8 cycles.
REQ-032 SHALL verify WIDTH=10, CHUNK=1: input 0x2AA -> done after 10 cycles, count=5, parity=1.
REQ-033 SHALL verify start held high through DONE for 5 cycles -> done stays 1 and count is unchanged; start low then high -> a new operation begins and count clears on the accept edge.
REQ-034 SHALL verify rst=0 at RUN cycle 4 -> the next edge gives IDLE, busy=0, done=0, count=0; a new start then yields the correct result.
REQ-035 SHALL verify input_number toggled every cycle during RUN -> the result equals the popcount of the value sampled at the accept edge.
